// File: rtl/mem_port_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state and owner encodings,
// plus the core's existing cache-data and register bus widths.
package mem_port_arb_pkg;

  localparam int CACHE_DATA_BUS_W = 32;
  localparam int REG_BUS_W        = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory-port arbiter.
// Ports: if_req, ls_req, last (previous winner) -> grant {ls, if}.
// MEM_ARB_RR_EN: round-robin on ties; otherwise LS wins ties.
import mem_port_arb_pkg::*;

module mem_arb_pick (
  input  logic       if_req,
  input  logic       ls_req,
  input  owner_t     last,
  output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant = {ls_req, if_req};
    if (if_req && ls_req) begin
      // the requester that did not win last time takes the tie
      grant = (last == OWN_LS) ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    grant = {ls_req, if_req};
    if (if_req && ls_req) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arb.sv
// Arbiter/sequencer sharing one Avalon-style cache port between fetch (if_*)
// and load/store (ls_*); one transaction at a time, responses routed to owner.
// Ports: clk, rst (async high), if_* / ls_* requesters, o_p_* / i_p_* port.
// MEM_ARB_RR_EN: round-robin tie breaking (fixed LS priority when undefined).
import mem_port_arb_pkg::*;

module mem_port_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_read,
  output logic              if_waitrequest,
  output logic [DATA_W-1:0] if_readdata,
  output logic              if_readdata_valid,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_read,
  input  logic              ls_write,
  input  logic [DATA_W-1:0] ls_writedata,
  input  logic [DATA_W/8-1:0] ls_byteenable,
  output logic              ls_waitrequest,
  output logic [DATA_W-1:0] ls_readdata,
  output logic              ls_readdata_valid,
  output logic [ADDR_W-1:0] o_p_addr,
  output logic              o_p_read,
  output logic              o_p_write,
  output logic [DATA_W-1:0] o_p_writedata,
  output logic [DATA_W/8-1:0] o_p_byteenable,
  input  logic              i_p_waitrequest,
  input  logic [DATA_W-1:0] i_p_readdata,
  input  logic              i_p_readdata_valid
);

  arb_state_t state, state_n;
  owner_t     owner;
  owner_t     last;

  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W/8-1:0] cmd_be;
  logic                cmd_write;

  logic       ls_req;
  logic       req_any;
  logic [1:0] grant;
  logic       in_cmd;
  logic       accept;
  logic       resp_hit;

  assign ls_req  = ls_read | ls_write;
  assign req_any = if_read | ls_req;
  assign in_cmd  = (state == ARB_CMD);
  assign accept  = in_cmd & ~i_p_waitrequest;

  // read data is taken either alongside acceptance or later in RESP;
  // anything seen in IDLE or before acceptance is stale
  assign resp_hit = i_p_readdata_valid &
                    ((accept & ~cmd_write) | (state == ARB_RESP));

  mem_arb_pick u_pick (
    .if_req (if_read),
    .ls_req (ls_req),
    .last   (last),
    .grant  (grant)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= OWN_LS;
    end else if (state == ARB_IDLE && req_any) begin
      last <= grant[1] ? OWN_LS : OWN_IF;
    end
  end
`else
  assign last = OWN_LS;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= OWN_LS;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_be    <= '0;
      cmd_write <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ARB_IDLE && req_any) begin
        if (grant[1]) begin
          owner     <= OWN_LS;
          cmd_addr  <= ls_addr;
          cmd_wdata <= ls_writedata;
          cmd_be    <= ls_byteenable;
          cmd_write <= ls_write;
        end else begin
          owner     <= OWN_IF;
          cmd_addr  <= if_addr;
          cmd_wdata <= '0;
          cmd_be    <= '1;
          cmd_write <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ARB_IDLE: if (req_any) state_n = ARB_CMD;
      ARB_CMD: begin
        if (accept) begin
          if (cmd_write || i_p_readdata_valid) state_n = ARB_IDLE;
          else                                 state_n = ARB_RESP;
        end
      end
      ARB_RESP: if (i_p_readdata_valid) state_n = ARB_IDLE;
      default:  state_n = ARB_IDLE;
    endcase
  end

  assign o_p_addr       = in_cmd ? cmd_addr : '0;
  assign o_p_read       = in_cmd & ~cmd_write;
  assign o_p_write      = in_cmd & cmd_write;
  assign o_p_writedata  = in_cmd ? cmd_wdata : '0;
  assign o_p_byteenable = in_cmd ? cmd_be : '0;

  // owner stalls on the port until accepted; everyone else stalls on
  // their own request
  assign if_waitrequest = (in_cmd && owner == OWN_IF) ?
                          i_p_waitrequest : if_read;
  assign ls_waitrequest = (in_cmd && owner == OWN_LS) ?
                          i_p_waitrequest : ls_req;

  assign if_readdata_valid = resp_hit & (owner == OWN_IF);
  assign ls_readdata_valid = resp_hit & (owner == OWN_LS);
  assign if_readdata = if_readdata_valid ? i_p_readdata : '0;
  assign ls_readdata = ls_readdata_valid ? i_p_readdata : '0;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed self-checking bench for mem_port_arb.
// Inputs change and outputs are checked 1ns after each rising edge.
import mem_port_arb_pkg::*;

module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_addr;
  logic        if_read;
  logic        if_waitrequest;
  logic [31:0] if_readdata;
  logic        if_readdata_valid;
  logic [31:0] ls_addr;
  logic        ls_read;
  logic        ls_write;
  logic [31:0] ls_writedata;
  logic [3:0]  ls_byteenable;
  logic        ls_waitrequest;
  logic [31:0] ls_readdata;
  logic        ls_readdata_valid;
  logic [31:0] o_p_addr;
  logic        o_p_read;
  logic        o_p_write;
  logic [31:0] o_p_writedata;
  logic [3:0]  o_p_byteenable;
  logic        i_p_waitrequest;
  logic [31:0] i_p_readdata;
  logic        i_p_readdata_valid;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_port_arb dut (
    .clk                (clk),
    .rst                (rst),
    .if_addr            (if_addr),
    .if_read            (if_read),
    .if_waitrequest     (if_waitrequest),
    .if_readdata        (if_readdata),
    .if_readdata_valid  (if_readdata_valid),
    .ls_addr            (ls_addr),
    .ls_read            (ls_read),
    .ls_write           (ls_write),
    .ls_writedata       (ls_writedata),
    .ls_byteenable      (ls_byteenable),
    .ls_waitrequest     (ls_waitrequest),
    .ls_readdata        (ls_readdata),
    .ls_readdata_valid  (ls_readdata_valid),
    .o_p_addr           (o_p_addr),
    .o_p_read           (o_p_read),
    .o_p_write          (o_p_write),
    .o_p_writedata      (o_p_writedata),
    .o_p_byteenable     (o_p_byteenable),
    .i_p_waitrequest    (i_p_waitrequest),
    .i_p_readdata       (i_p_readdata),
    .i_p_readdata_valid (i_p_readdata_valid)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_addr = '0; if_read = 0;
    ls_addr = '0; ls_read = 0; ls_write = 0;
    ls_writedata = '0; ls_byteenable = '0;
    i_p_waitrequest = 0; i_p_readdata = '0; i_p_readdata_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    if_read = 1;
    #3;
    total++;
    if ({o_p_read, o_p_write, o_p_addr, o_p_writedata, o_p_byteenable} !== '0)
      $display("FAIL reset_cmd got %b/%b addr=%h exp all 0", o_p_read, o_p_write, o_p_addr);
    else passed++;
    total++;
    if ({if_readdata_valid, ls_readdata_valid, if_readdata, ls_readdata} !== '0)
      $display("FAIL reset_resp got %b/%b exp 0", if_readdata_valid, ls_readdata_valid);
    else passed++;
    total++;
    if ({if_waitrequest, ls_waitrequest} !== 2'b10)
      $display("FAIL reset_wait got %b exp 10", {if_waitrequest, ls_waitrequest});
    else passed++;
    if_read = 0;
    cyc();
    rst = 0;
    cyc();
  endtask

  task automatic test_ls_load();
    ls_addr = 32'h100; ls_read = 1; i_p_waitrequest = 1;
    #1;
    total++;
    if ({ls_waitrequest, o_p_read} !== 2'b10)
      $display("FAIL load_idle got %b exp 10", {ls_waitrequest, o_p_read});
    else passed++;
    cyc();
    total++;
    if ({o_p_read, o_p_write, o_p_addr, ls_waitrequest} !== {2'b10, 32'h100, 1'b1})
      $display("FAIL load_cmd got r%b w%b a%h wr%b exp r1 w0 a100 wr1",
               o_p_read, o_p_write, o_p_addr, ls_waitrequest);
    else passed++;
    cyc();
    total++;
    if ({o_p_read, ls_waitrequest} !== 2'b11)
      $display("FAIL load_wait2 got %b exp 11", {o_p_read, ls_waitrequest});
    else passed++;
    cyc();
    i_p_waitrequest = 0;
    #1;
    total++;
    if ({o_p_read, ls_waitrequest, ls_readdata_valid} !== 3'b100)
      $display("FAIL load_accept got %b exp 100",
               {o_p_read, ls_waitrequest, ls_readdata_valid});
    else passed++;
    cyc();
    ls_read = 0;
    i_p_readdata = 32'hDEADBEEF; i_p_readdata_valid = 1;
    #1;
    total++;
    if ({ls_readdata_valid, ls_readdata, if_readdata_valid, o_p_read} !==
        {1'b1, 32'hDEADBEEF, 2'b00})
      $display("FAIL load_data got v%b d%h ifv%b r%b exp v1 dDEADBEEF ifv0 r0",
               ls_readdata_valid, ls_readdata, if_readdata_valid, o_p_read);
    else passed++;
    cyc();
    i_p_readdata_valid = 0; i_p_readdata = '0;
    #1;
    total++;
    if ({ls_readdata_valid, if_readdata_valid, dut.state} !== {2'b00, ARB_IDLE})
      $display("FAIL load_done got v%b st%0d exp v0 st0",
               ls_readdata_valid, dut.state);
    else passed++;
  endtask

  task automatic test_ls_store();
    ls_addr = 32'h240; ls_write = 1;
    ls_writedata = 32'h12345678; ls_byteenable = 4'hF;
    #1;
    total++;
    if (o_p_write !== 1'b0)
      $display("FAIL store_idle got %b exp 0", o_p_write);
    else passed++;
    cyc();
    total++;
    if ({o_p_write, o_p_read, o_p_writedata, o_p_byteenable, o_p_addr, ls_waitrequest} !==
        {2'b10, 32'h12345678, 4'hF, 32'h240, 1'b0})
      $display("FAIL store_cmd got w%b d%h be%h a%h wr%b exp w1 d12345678 beF a240 wr0",
               o_p_write, o_p_writedata, o_p_byteenable, o_p_addr, ls_waitrequest);
    else passed++;
    cyc();
    ls_write = 0;
    #1;
    total++;
    if ({o_p_write, dut.state} !== {1'b0, ARB_IDLE})
      $display("FAIL store_done got w%b st%0d exp w0 st0", o_p_write, dut.state);
    else passed++;
  endtask

  task automatic test_same_cycle();
    if_addr = 32'h200; if_read = 1;
    cyc();
    i_p_readdata = 32'hA5A5A5A5; i_p_readdata_valid = 1;
    #1;
    total++;
    if ({if_readdata_valid, if_readdata, if_waitrequest, ls_readdata_valid} !==
        {1'b1, 32'hA5A5A5A5, 2'b00})
      $display("FAIL same_cycle got v%b d%h wr%b lsv%b exp v1 dA5A5A5A5 wr0 lsv0",
               if_readdata_valid, if_readdata, if_waitrequest, ls_readdata_valid);
    else passed++;
    cyc();
    if_read = 0; i_p_readdata_valid = 0; i_p_readdata = '0;
    #1;
    total++;
    if ({if_readdata_valid, dut.state} !== {1'b0, ARB_IDLE})
      $display("FAIL same_cycle_idle got v%b st%0d exp v0 st0",
               if_readdata_valid, dut.state);
    else passed++;
  endtask

  task automatic test_tie();
    logic [31:0] exp_addr [4];
`ifdef MEM_ARB_RR_EN
    exp_addr = '{32'h400, 32'h500, 32'h400, 32'h500};
`else
    exp_addr = '{32'h500, 32'h500, 32'h500, 32'h500};
`endif
    rst = 1; #2; rst = 0;
    cyc();
    if_addr = 32'h400; if_read = 1;
    ls_addr = 32'h500; ls_read = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      i_p_readdata = 32'hC0DE0000 + i; i_p_readdata_valid = 1;
      #1;
      total++;
      if (o_p_addr !== exp_addr[i])
        $display("FAIL tie_grant%0d got %h exp %h", i, o_p_addr, exp_addr[i]);
      else passed++;
      total++;
      if ({if_waitrequest, if_readdata_valid, ls_waitrequest, ls_readdata_valid} !==
          ((exp_addr[i] == 32'h400) ? 4'b0110 : 4'b1001))
        $display("FAIL tie_route%0d got %b", i,
                 {if_waitrequest, if_readdata_valid, ls_waitrequest, ls_readdata_valid});
      else passed++;
      cyc();
      i_p_readdata_valid = 0;
    end
    if_read = 0; ls_read = 0;
    cyc();
  endtask

  task automatic test_stray();
    i_p_readdata = 32'h5555AAAA; i_p_readdata_valid = 1;
    #1;
    total++;
    if ({if_readdata_valid, ls_readdata_valid, if_readdata, ls_readdata} !== '0)
      $display("FAIL stray_idle got %b/%b exp 0", if_readdata_valid, ls_readdata_valid);
    else passed++;
    i_p_readdata_valid = 0;
    ls_addr = 32'h300; ls_read = 1; i_p_waitrequest = 1;
    cyc();
    i_p_readdata_valid = 1;
    #1;
    total++;
    if ({ls_readdata_valid, ls_waitrequest, o_p_read} !== 3'b011)
      $display("FAIL stray_cmd got %b exp 011",
               {ls_readdata_valid, ls_waitrequest, o_p_read});
    else passed++;
    i_p_readdata_valid = 0; i_p_waitrequest = 0;
    cyc();
    ls_read = 0;
    i_p_readdata_valid = 1; i_p_readdata = 32'h0BADF00D;
    #1;
    total++;
    if ({ls_readdata_valid, ls_readdata} !== {1'b1, 32'h0BADF00D})
      $display("FAIL stray_real got v%b d%h exp v1 d0BADF00D",
               ls_readdata_valid, ls_readdata);
    else passed++;
    cyc();
    i_p_readdata_valid = 0; i_p_readdata = '0;
  endtask

  task automatic test_reset_resp();
    ls_addr = 32'h700; ls_read = 1;
    cyc();
    cyc();
    ls_read = 0;
    #1;
    total++;
    if (dut.state !== ARB_RESP)
      $display("FAIL rr_setup got st%0d exp st2", dut.state);
    else passed++;
    #2;
    rst = 1;
    #1;
    total++;
    if ({dut.state, o_p_read, o_p_addr, ls_waitrequest, if_waitrequest} !==
        {ARB_IDLE, 1'b0, 32'h0, 2'b00})
      $display("FAIL rr_async got st%0d r%b a%h exp st0 r0 a0",
               dut.state, o_p_read, o_p_addr);
    else passed++;
    cyc();
    rst = 0;
    i_p_readdata = 32'hFEEDFACE; i_p_readdata_valid = 1;
    #1;
    total++;
    if ({ls_readdata_valid, if_readdata_valid, ls_readdata, if_readdata,
         o_p_read, o_p_write, ls_waitrequest, if_waitrequest} !== '0)
      $display("FAIL rr_late got lsv%b ifv%b d%h exp all 0",
               ls_readdata_valid, if_readdata_valid, ls_readdata);
    else passed++;
    cyc();
    i_p_readdata_valid = 0;
    #1;
    total++;
    if ({ls_readdata_valid, dut.state} !== {1'b0, ARB_IDLE})
      $display("FAIL rr_after got v%b st%0d exp v0 st0", ls_readdata_valid, dut.state);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_ls_load();
    cyc();
    test_ls_store();
    cyc();
    test_same_cycle();
    cyc();
    test_tie();
    test_stray();
    test_reset_resp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
